// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: the alu_defs constants shared with the ALU control decoder.
// Holds the 4-bit control codes, the multiplier state encoding and a small
// signed-overflow helper used by the execution unit.
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_ADD = 4'b0111;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_MUL = 4'b1100;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_MUL  = 2'd1,
    MS_FIX  = 2'd2
  } mul_state_e;

  // Signed overflow of a two's-complement add: both addends share a sign
  // and the sum's sign differs. For subtraction pass the inverted b sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    add_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative signed shift-add multiplier (IDLE -> MUL -> FIX).
// Multiplies operand magnitudes over N cycles and fixes the sign in FIX.
// done and the product are presented during the FIX cycle so the owner can
// register them on the same edge that ends the operation.
module alu_mul_iter
  import alu_exec_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] prod_hi,
  output logic [N-1:0] prod_lo
);

  localparam int CW = $clog2(N) + 1;

  mul_state_e     state_r;
  logic [2*N-1:0] acc_r;
  logic [N-1:0]   mcand_r;
  logic           sign_r;
  logic [CW-1:0]  count_r;
  logic           busy_r;

  logic [N:0]     step_sum_s;
  logic [2*N-1:0] prod_s;

  // Magnitude computed in N+1 bits so that -2^(N-1) maps to +2^(N-1).
  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    logic [N:0] ext;
    ext = {v[N-1], v};
    ext = v[N-1] ? (~ext + {{N{1'b0}}, 1'b1}) : ext;
    mag = ext[N-1:0];
  endfunction

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set; the carry becomes the new MSB.
  always_comb begin
    step_sum_s = {1'b0, acc_r[2*N-1:N]} +
                 {1'b0, (acc_r[0] ? mcand_r : {N{1'b0}})};
    if (sign_r) begin
      prod_s = ~acc_r + {{(2*N-1){1'b0}}, 1'b1};
    end else begin
      prod_s = acc_r;
    end
  end

  // Multiplier FSM and datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= MS_IDLE;
      acc_r   <= {(2*N){1'b0}};
      mcand_r <= {N{1'b0}};
      sign_r  <= 1'b0;
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        MS_IDLE: begin
          if (start) begin
            acc_r   <= {{N{1'b0}}, mag(b)};
            mcand_r <= mag(a);
            sign_r  <= a[N-1] ^ b[N-1];
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= MS_MUL;
          end else begin
            state_r <= MS_IDLE;
          end
        end
        MS_MUL: begin
          acc_r   <= {step_sum_s, acc_r[N-1:1]};
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CW'(N - 1)) begin
            state_r <= MS_FIX;
          end else begin
            state_r <= MS_MUL;
          end
        end
        MS_FIX: begin
          busy_r  <= 1'b0;
          state_r <= MS_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= MS_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = (state_r == MS_FIX);
  assign prod_hi = prod_s[2*N-1:N];
  assign prod_lo = prod_s[N-1:0];

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execution unit behind the 4-bit ALU control bus.
// Single-cycle ops register their result on the accepting edge; MUL runs
// on the iterative alu_mul_iter and stalls the pipeline through busy.
// Optional feature macro: ALU_EXEC_MUL_EN (MUL support; otherwise 1100 is
// reported as an illegal code and the unit never stalls).
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_control,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [4:0]   shamt,
  output logic         out_valid,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         zero,
  output logic         overflow,
  output logic         illegal,
  output logic         busy
);

  logic         accept_s;
  logic         mul_op_s;
  logic         mul_done_s;
  logic [N-1:0] mul_hi_s;
  logic [N-1:0] mul_lo_s;
  logic         mul_busy_s;

  logic [N-1:0] add_s;
  logic [N-1:0] sub_s;
  logic [N-1:0] comb_lo_s;
  logic         comb_ovf_s;
  logic         comb_ill_s;

  logic         out_valid_r;
  logic [N-1:0] result_lo_r;
  logic [N-1:0] result_hi_r;
  logic         zero_r;
  logic         overflow_r;
  logic         illegal_r;

  assign accept_s = in_valid && in_ready;

`ifdef ALU_EXEC_MUL_EN
  assign mul_op_s = (alu_control == ALU_MUL);

  alu_mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .rstb    (rstb),
    .start   (accept_s && mul_op_s),
    .a       (x),
    .b       (y),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .prod_hi (mul_hi_s),
    .prod_lo (mul_lo_s)
  );
`else
  assign mul_op_s   = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_hi_s   = {N{1'b0}};
  assign mul_lo_s   = {N{1'b0}};
  assign mul_busy_s = 1'b0;
`endif

  assign busy     = mul_busy_s;
  assign in_ready = !mul_busy_s;

  // Single-cycle result, overflow and illegal-code decode.
  always_comb begin
    add_s      = x + y;
    sub_s      = x - y;
    comb_lo_s  = {N{1'b0}};
    comb_ovf_s = 1'b0;
    comb_ill_s = 1'b0;
    case (alu_control)
      ALU_AND: comb_lo_s = x & y;
      ALU_OR:  comb_lo_s = x | y;
      ALU_XOR: comb_lo_s = x ^ y;
      ALU_NOR: comb_lo_s = ~(x | y);
      ALU_SLT: comb_lo_s = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_SLL: comb_lo_s = y << shamt;
      ALU_SRL: comb_lo_s = y >> shamt;
      ALU_SRA: comb_lo_s = $unsigned($signed(y) >>> shamt);
      ALU_ADD: begin
        comb_lo_s  = add_s;
        comb_ovf_s = add_ovf(x[N-1], y[N-1], add_s[N-1]);
      end
      ALU_SUB: begin
        comb_lo_s  = sub_s;
        comb_ovf_s = add_ovf(x[N-1], ~y[N-1], sub_s[N-1]);
      end
`ifdef ALU_EXEC_MUL_EN
      ALU_MUL: comb_lo_s = {N{1'b0}};
`endif
      default: begin
        comb_lo_s  = {N{1'b0}};
        comb_ill_s = 1'b1;
      end
    endcase
  end

  // Output registers: load on single-cycle accept or multiplier completion.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid_r <= 1'b0;
      result_lo_r <= {N{1'b0}};
      result_hi_r <= {N{1'b0}};
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      result_lo_r <= mul_lo_s;
      result_hi_r <= mul_hi_s;
      zero_r      <= (mul_lo_s == {N{1'b0}});
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (accept_s && !mul_op_s) begin
      out_valid_r <= 1'b1;
      result_lo_r <= comb_lo_s;
      result_hi_r <= {N{1'b0}};
      zero_r      <= (comb_lo_s == {N{1'b0}});
      overflow_r  <= comb_ovf_s;
      illegal_r   <= comb_ill_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign result_lo = result_lo_r;
  assign result_hi = result_hi_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed-vector scoreboard bench for alu_exec.
// The driver pushes expected results (with the cycle they must appear in);
// a negedge monitor pops and compares whenever out_valid is high.
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rstb;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [4:0]   shamt;
  logic         out_valid;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         illegal;
  logic         busy;

  typedef struct {
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic         z;
    logic         ov;
    logic         il;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_exec #(.N(N)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .x           (x),
    .y           (y),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .zero        (zero),
    .overflow    (overflow),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Edge counter used to stamp expected completion cycles.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every presented result.
  always @(negedge clk) begin
    if (rstb === 1'b1 && out_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid got lo=%h hi=%h want no result", result_lo, result_hi);
      end else begin
        mon_e = q.pop_front();
        if ({result_hi, result_lo, zero, overflow, illegal} !==
            {mon_e.hi, mon_e.lo, mon_e.z, mon_e.ov, mon_e.il}) begin
          bad++;
          $display("FAIL result got hi=%h lo=%h z=%b ov=%b il=%b want hi=%h lo=%h z=%b ov=%b il=%b",
                   result_hi, result_lo, zero, overflow, illegal,
                   mon_e.hi, mon_e.lo, mon_e.z, mon_e.ov, mon_e.il);
        end
        total++;
        if (cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL latency got cycle=%0d want cycle=%0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [4:0] sh, input logic [N-1:0] elo, input logic [N-1:0] ehi,
                       input logic ez, input logic eov, input logic eil, input int lat);
    exp_t t;
    @(negedge clk);
    alu_control = c;
    x = a;
    y = b;
    shamt = sh;
    in_valid = 1'b1;
    t.lo = elo; t.hi = ehi; t.z = ez; t.ov = eov; t.il = eil;
    t.cyc = cyc + 1 + lat;
    q.push_back(t);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {56'd0, out_valid, zero, overflow, illegal, busy, 3'b000}, 64'd0);
    chk({name, "_res"}, {result_hi, result_lo}, 64'd0);
  endtask

  initial begin
    rstb = 1'b0;
    in_valid = 1'b0;
    alu_control = 4'b0000;
    x = '0;
    y = '0;
    shamt = 5'd0;

    #12;
    check_zero_outputs("reset_state");
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstb = 1'b1;

    // Single-cycle ops, issued back to back.
    issue(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 0);
    issue(ALU_SUB, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    issue(ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    issue(ALU_SRA, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_SRL, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_SLL, 32'h0, 32'h00000003, 5'd31, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_AND, 32'hA5A5F00F, 32'h0FF0FFFF, 5'd0, 32'h05A0F00F, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_OR,  32'h0F0F0000, 32'h00F000F0, 5'd0, 32'h0FFF00F0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    issue(ALU_SUB, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 0);
    issue(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    issue(4'b1001, 32'h12345678, 32'h9ABCDEF0, 5'd0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    issue(4'b1010, 32'h00000001, 32'h00000001, 5'd0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    issue(ALU_NOR, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();

    // Asynchronous reset while a result is being held.
    chk("pre_reset_hold", 64'(result_lo), 64'hFFFFFFFF);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    issue(ALU_ADD, 32'h00000002, 32'h00000003, 5'd0, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();

`ifdef ALU_EXEC_MUL_EN
    // MUL -3 * 7 with requests presented while busy (must be ignored).
    issue(ALU_MUL, 32'hFFFFFFFD, 32'h00000007, 5'd0, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, N + 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("in_ready_low_busy", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      alu_control = ALU_ADD;
      x = 32'(i);
      y = 32'h1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    // Most-negative operand times -1.
    issue(ALU_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, N + 1);
    wait_idle();

    // Abort a multiply at count 10; no result may appear.
    issue(ALU_MUL, 32'h00000005, 32'h00000006, 5'd0, 32'h0000001E, 32'h0, 1'b0, 1'b0, 1'b0, N + 1);
    repeat (10) @(negedge clk);
    #2 rstb = 1'b0;
    q.delete();
    #1;
    check_zero_outputs("mul_abort_reset");
    @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("ready_after_abort", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    issue(ALU_ADD, 32'h00000010, 32'h00000020, 5'd0, 32'h00000030, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();
`else
    // Without the multiplier, 1100 is an illegal single-cycle code.
    issue(4'b1100, 32'hFFFFFFFD, 32'h00000007, 5'd0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    issue(ALU_ADD, 32'h00000010, 32'h00000020, 5'd0, 32'h00000030, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();
    chk("no_busy", 64'({busy, in_ready}), 64'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
